// File: rtl/tlc_pkg.sv
// tlc_pkg: shared light and phase encodings for the multi-way traffic controller
package tlc_pkg;
  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_GREEN  = 3'b010;
  localparam logic [2:0] LT_YELLOW = 3'b001;
  typedef enum logic [1:0] {
    PH_ALLRED = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10
  } phase_t;
endpackage

// File: rtl/tlc_rr_pick.sv
// tlc_rr_pick: round-robin pick of the first requesting approach after cur
module tlc_rr_pick
  import tlc_pkg::*;
#(
  parameter int N_WAY = 4,
  parameter int IDW   = $clog2(N_WAY)
) (
  input  logic [N_WAY-1:0] req,
  input  logic [IDW-1:0]   cur,
  output logic [IDW-1:0]   pick,
  output logic             pick_vld
);
  logic [IDW-1:0] idx;
  // scan from the farthest candidate back so the nearest requester after cur wins
  always_comb begin
    pick = cur;
    pick_vld = 1'b0;
    idx = '0;
    for (int k = N_WAY; k >= 1; k--) begin
      idx = IDW'((int'(cur) + k) % N_WAY);
      if (req[idx]) begin
        pick = idx;
        pick_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tlc_multiway.sv
// tlc_multiway: N-approach round-robin traffic controller with min/max green and preempt
module tlc_multiway
  import tlc_pkg::*;
#(
  parameter int N_WAY      = 4,
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 16,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int IDW        = $clog2(N_WAY)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_WAY-1:0]     req,
  input  logic                 preempt_vld,
  input  logic [IDW-1:0]       preempt_id,
  output logic [3*N_WAY-1:0]   lights,
  output logic [IDW-1:0]       active_id,
  output logic [1:0]           phase
);
  localparam int TMAX = YELLOW_CYC > ALLRED_CYC ? YELLOW_CYC : ALLRED_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int GW   = $clog2(MAX_GREEN + 1);
  phase_t state, state_n;
  logic [IDW-1:0] id_n, pick;
  logic pick_vld, pre_ok, other;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [3*N_WAY-1:0] lights_n;
  tlc_rr_pick #(.N_WAY(N_WAY), .IDW(IDW)) u_pick (
    .req      (req),
    .cur      (active_id),
    .pick     (pick),
    .pick_vld (pick_vld)
  );
  assign pre_ok = preempt_vld && (int'(preempt_id) < N_WAY);
  assign other  = |(req & ~(N_WAY'(1) << active_id));
  assign phase  = state;
  // next phase, owner, counters and the light pattern that goes with them
  always_comb begin
    state_n = state;
    id_n = active_id;
    gcnt_n = gcnt;
    tmr_n = tmr;
    lights_n = '0;
    case (state)
      PH_ALLRED:
        if (tmr > TW'(1)) tmr_n = tmr - TW'(1);
        else if (pre_ok || pick_vld) begin
          state_n = PH_GREEN;
          id_n = pre_ok ? preempt_id : pick;
          gcnt_n = GW'(1);
        end
      PH_GREEN: begin
        gcnt_n = gcnt >= GW'(MAX_GREEN) ? gcnt : gcnt + GW'(1);
        if (pre_ok ? (preempt_id != active_id)
                   : (other && (gcnt >= GW'(MAX_GREEN) || (gcnt >= GW'(MIN_GREEN) && !req[active_id])))) begin
          state_n = PH_YELLOW;
          tmr_n = TW'(YELLOW_CYC);
        end
      end
      PH_YELLOW:
        if (tmr > TW'(1)) tmr_n = tmr - TW'(1);
        else begin
          state_n = PH_ALLRED;
          tmr_n = TW'(ALLRED_CYC);
        end
      default: state_n = PH_ALLRED;
    endcase
    for (int i = 0; i < N_WAY; i++)
      lights_n[3*i +: 3] = (state_n == PH_ALLRED || id_n != IDW'(i)) ? LT_RED
                         : (state_n == PH_GREEN ? LT_GREEN : LT_YELLOW);
  end
  // state registers; reset forces every approach to red at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PH_ALLRED;
      active_id <= '0;
      gcnt <= '0;
      tmr <= TW'(ALLRED_CYC);
      lights <= {N_WAY{LT_RED}};
    end else begin
      state <= state_n;
      active_id <= id_n;
      gcnt <= gcnt_n;
      tmr <= tmr_n;
      lights <= lights_n;
    end
  end
endmodule

// File: tb/tb_tlc_multiway.sv
// tb_tlc_multiway: directed and soak checks of the multi-way traffic controller
module tb_tlc_multiway;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic preempt_vld;
  logic [1:0] preempt_id;
  logic [11:0] lights;
  logic [1:0] active_id, phase;
  int npass = 0, ntot = 0, nfail = 0;
  int run, nonred;
  logic [1:0] pph, nph;
  logic [2:0] slc, want;

  tlc_multiway #(
    .N_WAY(4), .MIN_GREEN(4), .MAX_GREEN(8), .YELLOW_CYC(2), .ALLRED_CYC(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .preempt_vld (preempt_vld),
    .preempt_id  (preempt_id),
    .lights      (lights),
    .active_id   (active_id),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input int l, input int p, input int a);
    chk({tag, "_lt"}, int'(lights), l);
    chk({tag, "_ph"}, int'(phase), p);
    chk({tag, "_id"}, int'(active_id), a);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; preempt_vld = 1'b0; preempt_id = 2'd0;
    for (int i = 0; i < 20; i++) begin tick(); look("rst_idle", 'h924, 0, 0); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); look("rest", 'h924, 0, 0); end
    // release with approach 0 requesting: green after one edge, then held
    rst = 1'b1; tick(); req = 4'b0001; rst = 1'b0;
    tick(); look("lat", 'h922, 1, 0);
    for (int i = 0; i < 30; i++) begin tick(); look("hold", 'h922, 1, 0); end
    // max green with competing request on approach 2
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); look("mx_g1", 'h922, 1, 0); req = 4'b0101;
    for (int i = 2; i <= 8; i++) begin tick(); look("mx_g", 'h922, 1, 0); end
    tick(); look("mx_y1", 'h921, 2, 0);
    tick(); look("mx_y2", 'h921, 2, 0);
    tick(); look("mx_ar", 'h924, 0, 0);
    tick(); look("mx_g2", 'h8a4, 1, 2);
    // min green, then skip of empty approach 2 from owner 1
    rst = 1'b1; req = 4'b0010; tick(); rst = 1'b0;
    tick(); look("sk_g1", 'h914, 1, 1); req = 4'b1001;
    for (int i = 2; i <= 4; i++) begin tick(); look("sk_g", 'h914, 1, 1); end
    tick(); look("sk_y1", 'h90c, 2, 1);
    tick(); look("sk_y2", 'h90c, 2, 1);
    tick(); look("sk_ar", 'h924, 0, 1);
    tick(); look("sk_g3", 'h524, 1, 3);
    // preempt to approach 2 cuts green short and then holds it
    rst = 1'b1; req = 4'b0001; tick(); rst = 1'b0;
    tick(); tick(); look("pe_g", 'h922, 1, 0);
    preempt_vld = 1'b1; preempt_id = 2'd2;
    tick(); look("pe_y1", 'h921, 2, 0);
    tick(); look("pe_y2", 'h921, 2, 0);
    tick(); look("pe_ar", 'h924, 0, 0);
    tick(); look("pe_g2", 'h8a4, 1, 2);
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin tick(); look("pe_hold", 'h8a4, 1, 2); end
    preempt_vld = 1'b0;
    tick(); look("pe_rel", 'h864, 2, 2);
    // asynchronous reset in the middle of yellow
    #1 rst = 1'b1;
    #1 look("ry", 'h924, 0, 0);
    req = 4'b0001;
    tick(); look("ry_hold", 'h924, 0, 0);
    rst = 1'b0;
    tick(); look("ry_g", 'h922, 1, 0);
    // random soak with sequence, duration and single-owner checks
    rst = 1'b1; req = 4'b0000; tick(); rst = 1'b0;
    pph = 2'b00; run = 1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        preempt_vld = ~preempt_vld;
        preempt_id = 2'($urandom);
      end
      tick();
      nonred = 0;
      for (int i = 0; i < 4; i++) if (lights[3*i +: 3] != 3'b100) nonred++;
      chk("soak_one", nonred, (phase == 2'b00) ? 0 : 1);
      slc = lights[int'(active_id)*3 +: 3];
      want = phase == 2'b01 ? 3'b010 : phase == 2'b10 ? 3'b001 : 3'b100;
      chk("soak_lt", int'(slc), int'(want));
      if (phase != pph) begin
        nph = pph == 2'b00 ? 2'b01 : pph == 2'b01 ? 2'b10 : 2'b00;
        chk("soak_seq", int'(phase), int'(nph));
        if (pph == 2'b10) chk("soak_yel", run, 2);
        run = 1;
        pph = phase;
      end else run++;
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/tlc_multiway.md
# tlc_multiway

Parametrised N-approach traffic-light controller, successor to the two-road sensor-driven controller. It serves N_WAY approaches in round-robin order, skipping approaches with no vehicle request. Green time is bounded by minimum and maximum timers. Every change of right-of-way passes through a timed yellow phase and an all-red clearance phase. An emergency-preempt input forces right-of-way to a chosen approach.

## Interface
Parameters:
- N_WAY, 4: number of approaches; must be ≥2.
- MIN_GREEN, 4: minimum green length in cycles; must be ≥1.
- MAX_GREEN, 16: maximum green length in cycles while any other approach is waiting; must be ≥MIN_GREEN.
- YELLOW_CYC, 2: yellow length in cycles; must be ≥1.
- ALLRED_CYC, 1: all-red clearance length in cycles; must be ≥1.
- IDW, $clog2(N_WAY): width of the approach index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- req  in  N_WAY  per-approach vehicle-present sensor, level-sensitive.
- preempt_vld  in  1  emergency preempt active, level-sensitive.
- preempt_id  in  IDW  approach to be given right-of-way. Ignored if ≥N_WAY.
- lights  out  3*N_WAY  lights[3i+2:3i] = {red,green,yellow} for approach i. 100 = red, 010 = green, 001 = yellow.
- active_id  out  IDW  approach currently owning (or last owning) right-of-way.
- phase  out  2  00 = ALLRED, 01 = GREEN, 10 = YELLOW.

## Operation
- Three-state FSM: ALLRED, GREEN, YELLOW. All outputs are registered and derived from the state registers.
- Reset values:
  - phase = ALLRED, active_id = 0, all lights = 100.
  - Clearance timer is loaded with ALLRED_CYC; green counter gcnt = 0.
- ALLRED:
  - The timer counts down once per cycle.
  - When the timer expires, pick the next approach:
    - If preempt_vld and preempt_id is valid, pick preempt_id.
    - Otherwise run the round-robin pick over req, scanning cur+1, cur+2, …, cur+N_WAY (mod N_WAY).
  - If an approach is picked: go to GREEN, set active_id to it, set gcnt = 1.
  - If nothing is requested: stay in ALLRED (rest in red) and re-evaluate every cycle.
- GREEN:
  - Only approach active_id shows 010; all others show 100.
  - gcnt increments each cycle and saturates at MAX_GREEN.
  - other = any req bit other than active_id is set.
  - Exit rules, in priority order:
    1. preempt_vld with a valid preempt_id ≠ active_id: go to YELLOW on the next edge. This ignores MIN_GREEN.
    2. preempt_vld with preempt_id = active_id: hold GREEN.
    3. other && (gcnt ≥ MAX_GREEN || (gcnt ≥ MIN_GREEN && !req[active_id])): go to YELLOW.
    4. Otherwise hold GREEN indefinitely, including when no approach is requesting at all.
- YELLOW:
  - Approach active_id shows 001 for exactly YELLOW_CYC cycles.
  - Then go to ALLRED with the timer reloaded to ALLRED_CYC.
  - Yellow is never shortened, including by preempt.
- Invariant: at most one approach is ever non-red. No cycle has green→green between different approaches without passing through yellow and all-red.
- Reset mid-operation returns all lights to red immediately (asynchronously) and restores the reset values listed above.

## Timing
- Latency from reset release with req = 0001: green on approach 0 appears after ALLRED_CYC clock edges.
- Phase durations in cycles:
  - Green lasts ≥MIN_GREEN (except on preempt) and ≤MAX_GREEN while other requests are pending.
  - Yellow lasts exactly YELLOW_CYC.
  - All-red lasts exactly ALLRED_CYC, plus any rest time.
- Request changes take effect at the next clock edge; there is no sensor latching.
- req going high on the active approach during YELLOW does not return the controller to GREEN.
- Simultaneous preempt and req: preempt wins the ALLRED pick.

## Structure
- Shared package tlc_pkg holds:
  - Light encodings LT_RED, LT_GREEN, LT_YELLOW.
  - Phase encodings PH_ALLRED, PH_GREEN, PH_YELLOW.
- Sub-module tlc_rr_pick: combinational round-robin arbiter.
  - Inputs: req[N_WAY], cur[IDW].
  - Outputs: pick[IDW], pick_vld.
- Top level holds the FSM, the gcnt counter, the yellow/all-red timer and the light decode.

## Test plan
Settings for all scenarios: N_WAY = 4, MIN_GREEN = 4, MAX_GREEN = 8, YELLOW_CYC = 2, ALLRED_CYC = 1.
- Reset, req = 0000 for 20 cycles -> lights = 100_100_100_100, phase = 00 throughout.
- Release reset with req = 0001 -> after 1 edge, lights[2:0] = 010 and the rest are 100; green held for 30 cycles with no change.
- Green on 0, req = 0101 held -> 8 green cycles, 2 yellow (lights[2:0] = 001), 1 all-red, then green on 2 (active_id = 2).
- active_id = 1 in ALLRED, req = 1001 -> next green is approach 3, not 0; verify skip of the empty approach 2.
- Green on 0 at gcnt = 2, preempt_vld = 1, preempt_id = 2 -> yellow on 0 the next cycle, 2 yellow, 1 all-red, green on 2; green held while preempt_vld stays high, even with req = 1111.
- Assert rst during YELLOW -> all lights 100 immediately, phase = 00, active_id = 0; normal sequence resumes after release.
- Run a random req/preempt soak with a checker enforcing the single-non-red invariant and the minimum yellow and all-red durations.
